// File: rtl/fibonacci_generator_pkg.sv
// Shared constants for the Fibonacci generator: state codes, default widths
// and the largest representable result.
package fibonacci_generator_pkg;

    localparam int unsigned FIB_WIDTH     = 32;
    localparam int unsigned FIB_IDX_WIDTH = 6;
    localparam int unsigned FIB_MAX_INDEX = 47;

    // F(FIB_MAX_INDEX), the largest Fibonacci number that fits in 32 bits
    localparam logic [31:0] FIB_MAX_VALUE = 32'hB11924E1;

    // Codes match the classifier's state export so the two can share benches
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_ITER = 4'd1,
        S_DONE = 4'd7,
        S_OVF  = 4'd8
    } fib_state_e;

endpackage

// File: rtl/fibonacci_generator.sv
// Iterative Fibonacci generator: computes F(index_i) with one addition per
// clock, using a go/done handshake and a 4-bit state export.
module fibonacci_generator
    import fibonacci_generator_pkg::*;
#(
    parameter int unsigned WIDTH     = FIB_WIDTH,
    parameter int unsigned IDX_WIDTH = FIB_IDX_WIDTH,
    parameter int unsigned MAX_INDEX = FIB_MAX_INDEX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go_i,
    input  logic [IDX_WIDTH-1:0] index_i,
    output logic [WIDTH-1:0]     number_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic [3:0]           state_o
);

    localparam logic [IDX_WIDTH-1:0] MAX_IDX = IDX_WIDTH'(MAX_INDEX);

    fib_state_e           state, state_d;
    logic [IDX_WIDTH-1:0] idx, idx_d;
    logic [IDX_WIDTH-1:0] cnt, cnt_d;
    logic [WIDTH-1:0]     a, a_d;
    logic [WIDTH-1:0]     b, b_d;
    logic [WIDTH-1:0]     number_d;

    // Next-state and datapath update
    always_comb begin
        state_d  = state;
        idx_d    = idx;
        cnt_d    = cnt;
        a_d      = a;
        b_d      = b;
        number_d = number_o;

        case (state)
            S_IDLE: begin
                if (go_i) begin
                    number_d = '0;
                    if (index_i > MAX_IDX) begin
                        state_d = S_OVF;
                    end else begin
                        idx_d   = index_i;
                        a_d     = '0;
                        b_d     = WIDTH'(1);
                        cnt_d   = '0;
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                if (cnt == idx) begin
                    number_d = a;
                    state_d  = S_DONE;
                end else begin
                    // b may wrap on the last step for MAX_INDEX; it is never output
                    a_d   = b;
                    b_d   = a + b;
                    cnt_d = cnt + IDX_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (!go_i) begin
                    state_d = S_IDLE;
                end
            end
            S_OVF: begin
                number_d = '0;
                if (!go_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            a          <= '0;
            b          <= WIDTH'(1);
            number_o   <= '0;
            done_o     <= 1'b0;
            overflow_o <= 1'b0;
            state_o    <= 4'd0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            a          <= a_d;
            b          <= b_d;
            number_o   <= number_d;
            done_o     <= (state_d == S_DONE);
            overflow_o <= (state_d == S_OVF);
            state_o    <= state_d;
        end
    end

endmodule

// File: tb/tb_fibonacci_generator.sv
// Self-checking bench for fibonacci_generator: directed corner cases plus
// randomized runs against a table of Fibonacci numbers.
module tb_fibonacci_generator;
    import fibonacci_generator_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        go_i;
    logic [5:0]  index_i;
    logic [31:0] number_o;
    logic        done_o;
    logic        overflow_o;
    logic [3:0]  state_o;

    int tests_run    = 0;
    int tests_failed = 0;

    longint unsigned fib_tab [0:63];

    always #5 clk = ~clk;

    fibonacci_generator dut (
        .clk        (clk),
        .reset      (reset),
        .go_i       (go_i),
        .index_i    (index_i),
        .number_o   (number_o),
        .done_o     (done_o),
        .overflow_o (overflow_o),
        .state_o    (state_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete request: start, wait for result, hold go, then release
    task automatic run(input int n, input int hold, input int new_idx, input int change_at);
        int          cyc;
        bit          ovf;
        int          lat;
        logic [31:0] exp_num;
        ovf     = (n > 47);
        lat     = ovf ? 1 : n + 2;
        exp_num = ovf ? 32'd0 : 32'(fib_tab[n]);
        go_i    = 1'b1;
        index_i = 6'(n);
        cyc     = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == change_at) index_i = 6'(new_idx);
            if (cyc < lat) check($sformatf("iter_state n=%0d c=%0d", n, cyc), 64'(state_o), 64'(S_ITER));
        end while (!done_o && !overflow_o && cyc < 100);
        check($sformatf("latency n=%0d", n), 64'(cyc), 64'(lat));
        check($sformatf("number n=%0d", n), 64'(number_o), 64'(exp_num));
        check($sformatf("state n=%0d", n), 64'(state_o), ovf ? 64'(S_OVF) : 64'(S_DONE));
        check($sformatf("done n=%0d", n), 64'(done_o), 64'(!ovf));
        check($sformatf("ovf n=%0d", n), 64'(overflow_o), 64'(ovf));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold_state n=%0d", n), 64'(state_o), ovf ? 64'(S_OVF) : 64'(S_DONE));
            check($sformatf("hold_number n=%0d", n), 64'(number_o), 64'(exp_num));
        end
        go_i = 1'b0;
        @(posedge clk); #1;
        check($sformatf("idle_state n=%0d", n), 64'(state_o), 64'(S_IDLE));
        check($sformatf("idle_flags n=%0d", n), 64'({done_o, overflow_o}), 64'(0));
        check($sformatf("idle_number n=%0d", n), 64'(number_o), 64'(exp_num));
    endtask

    initial begin
        fib_tab[0] = 0;
        fib_tab[1] = 1;
        for (int i = 2; i < 64; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];

        reset   = 1'b0;
        go_i    = 1'b0;
        index_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({number_o, done_o, overflow_o, state_o}), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle_no_go", 64'(state_o), 64'(S_IDLE));

        run(11, 0, 0, 0);
        check("fib11_value", 64'(number_o), 64'(89));
        run(0, 0, 0, 0);
        run(1, 0, 0, 0);
        run(47, 0, 0, 0);
        check("fib47_value", 64'(number_o), 64'hB11924E1);
        run(48, 2, 0, 0);
        run(63, 0, 0, 0);
        run(11, 20, 0, 0);
        run(11, 0, 40, 3);
        check("idx_change_value", 64'(number_o), 64'(89));

        // Asynchronous reset in the middle of a long computation
        go_i    = 1'b1;
        index_i = 6'd30;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrun_reset_state", 64'(state_o), 64'(S_IDLE));
        check("midrun_reset_outs", 64'({number_o, done_o, overflow_o}), 64'(0));
        go_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        run(5, 0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            run(int'($urandom_range(0, 63)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 63)), int'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
